// File: rtl/fifo_rd_pkg.sv
// fifo_rd_pkg: shared types, defaults and helpers for the FIFO read-side byte packer.
package fifo_rd_pkg;

   typedef enum logic [1:0] {FILL, DRAIN, EMIT} state_t;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_PACK_N     = 4;

   // One bit of the keep mask: lane is live when it is below the landed byte count.
   function automatic logic keep_bit(input int n, input int lane);
      return lane < n;
   endfunction

endpackage

// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: pops bytes from the async FIFO read port and packs PACK_N of them per word.
// A flush emits any partial word with a lane keep mask so a burst tail is never stranded.
module fifo_rd_packer
   import fifo_rd_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int PACK_N     = DEF_PACK_N
) (
   input  logic                         r_clk,
   input  logic                         rrst_n,
   input  logic                         fifo_empty,
   input  logic [DATA_WIDTH-1:0]        fifo_data,
   output logic                         fifo_r_en,
   input  logic                         flush,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [DATA_WIDTH*PACK_N-1:0] out_data,
   output logic [PACK_N-1:0]            out_keep,
   output logic [15:0]                  out_words
);

   localparam int            CW       = $clog2(PACK_N + 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(PACK_N);
   localparam logic [CW:0]   LIM      = (CW + 1)'(PACK_N);

   state_t                             state, state_nxt;
   logic                               run, rd_pend;
   logic [CW-1:0]                      cnt;
   logic [PACK_N-1:0][DATA_WIDTH-1:0]  acc, part;
   logic [PACK_N-1:0]                  keep_nxt;
   logic                               slot_free, full, room, load;

   always_comb begin
      slot_free = !out_valid || out_ready;
      full      = cnt == CNT_FULL;
      room      = ({1'b0, cnt} + {{CW{1'b0}}, rd_pend}) < LIM;
      load      = slot_free && ((state == FILL && full) || (state == EMIT && cnt != '0));
      // Counting the in-flight pop keeps cnt + rd_pend within PACK_N.
      fifo_r_en = run && !fifo_empty && state == FILL && !flush && (room || (full && slot_free));
      for (int i = 0; i < PACK_N; i++) begin
         keep_nxt[i] = keep_bit(int'(cnt), i);
         part[i]     = keep_nxt[i] ? acc[i] : '0;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         FILL:    state_nxt = flush ? DRAIN : FILL;
         DRAIN:   state_nxt = rd_pend ? DRAIN : EMIT;
         default: state_nxt = (cnt == '0 || slot_free) ? FILL : EMIT;
      endcase
   end

   always_ff @(posedge r_clk or negedge rrst_n)
      if (!rrst_n) state <= FILL;
      else         state <= state_nxt;

   always_ff @(posedge r_clk or negedge rrst_n)
      if (!rrst_n) begin
         run       <= 1'b0;
         rd_pend   <= 1'b0;
         cnt       <= '0;
         acc       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_keep  <= '0;
         out_words <= '0;
      end else begin
         run     <= 1'b1;
         rd_pend <= fifo_r_en;
         for (int i = 0; i < PACK_N; i++)
            if (rd_pend && cnt == CW'(i)) acc[i] <= fifo_data;
         cnt <= load ? '0 : cnt + CW'(rd_pend);
         if (out_valid && out_ready) out_words <= out_words + 16'd1;
         // A full word has every lane live, so the masked view serves both loads.
         if (load) begin
            out_valid <= 1'b1;
            out_data  <= part;
            out_keep  <= keep_nxt;
         end else if (out_ready) out_valid <= 1'b0;
      end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb_fifo_rd_packer: directed table and hand sequences for the FIFO read-side packer,
// driving a 1-cycle-latency FIFO model and checking words, masks, stalls, reset and counter wrap.
module tb_fifo_rd_packer;

   typedef struct {
      int          n;
      logic [31:0] bytes;
      logic        fl;
      logic [31:0] data;
      logic [3:0]  keep;
   } vec_t;

   logic        r_clk = 1'b0;
   logic        rrst_n = 1'b0;
   logic        flush = 1'b0;
   logic        out_ready = 1'b1;
   logic        fifo_empty, fifo_r_en, out_valid;
   logic [7:0]  fifo_data;
   logic [31:0] out_data;
   logic [3:0]  out_keep;
   logic [15:0] out_words;

   logic [7:0]  mem [256];
   int          wr_ptr = 0, rd_ptr = 0, cyc = 0, viol = 0;
   int          checks = 0, errors = 0, exp_words = 0;
   logic [35:0] got [$];
   int          got_cyc [$];

   fifo_rd_packer #(.DATA_WIDTH(8), .PACK_N(4)) dut (
      .r_clk(r_clk), .rrst_n(rrst_n), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
      .fifo_r_en(fifo_r_en), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_keep(out_keep), .out_words(out_words)
   );

   always #5 r_clk = ~r_clk;

   assign fifo_empty = rd_ptr == wr_ptr;

   always @(posedge r_clk or negedge rrst_n)
      if (!rrst_n) fifo_data <= '0;
      else if (fifo_r_en) begin
         fifo_data <= mem[rd_ptr % 256];
         rd_ptr    <= rd_ptr + 1;
      end

   always @(posedge r_clk) begin
      cyc <= cyc + 1;
      if (rrst_n && fifo_r_en && fifo_empty) viol <= viol + 1;
      if (rrst_n && out_valid && out_ready) begin
         got.push_back({out_keep, out_data});
         got_cyc.push_back(cyc);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge r_clk);
   endtask

   task automatic push(input logic [7:0] b);
      mem[wr_ptr % 256] = b;
      wr_ptr++;
   endtask

   task automatic wait_valid(input int bound, input string name);
      int i;
      i = 0;
      do begin
         step(1);
         i++;
      end while (!out_valid && i < bound);
      chk({name, "_valid"}, 36'(out_valid), 36'd1);
   endtask

   task automatic take(input logic [31:0] d, input logic [3:0] k, input string name);
      chk({name, "_data"}, 36'(out_data), 36'(d));
      chk({name, "_keep"}, 36'(out_keep), 36'(k));
      step(1);
      exp_words++;
      chk({name, "_words"}, 36'(out_words), 36'(exp_words));
      chk({name, "_drop"}, 36'(out_valid), 36'd0);
   endtask

   function automatic logic [35:0] got_at(input int idx);
      return idx < got.size() ? got[idx] : '1;
   endfunction

   initial begin
      vec_t        tbl [5];
      logic [35:0] bp_exp [3];
      int          base, gb, n, unstable;
      logic        seen;

      tbl[0] = '{4, 32'h01020304, 1'b0, 32'h01020304, 4'hF};
      tbl[1] = '{2, 32'h0000CDAB, 1'b1, 32'h0000CDAB, 4'h3};
      tbl[2] = '{1, 32'h00000011, 1'b1, 32'h00000011, 4'h1};
      tbl[3] = '{3, 32'h00443322, 1'b1, 32'h00443322, 4'h7};
      tbl[4] = '{4, 32'h00FFA55A, 1'b0, 32'h00FFA55A, 4'hF};
      bp_exp[0] = 36'hF13121110;
      bp_exp[1] = 36'hF17161514;
      bp_exp[2] = 36'hF1B1A1918;

      // Reset values and start-up.
      step(2);
      chk("rst_valid", 36'(out_valid), 36'd0);
      chk("rst_data",  36'(out_data),  36'd0);
      chk("rst_keep",  36'(out_keep),  36'd0);
      chk("rst_words", 36'(out_words), 36'd0);
      push(8'hAB); push(8'hCD); push(8'hEF); push(8'h01);
      step(1);
      chk("rst_hold_ren", 36'(fifo_r_en), 36'd0);
      rrst_n = 1'b1;
      #1 chk("start_ren0", 36'(fifo_r_en), 36'd0);
      step(1);
      chk("start_ren1", 36'(fifo_r_en), 36'd1);
      wait_valid(6, "start");
      take(32'h01EFCDAB, 4'hF, "start");

      // Directed table: full words and flushed partial words.
      for (int t = 0; t < 5; t++) begin
         for (int i = 0; i < tbl[t].n; i++) push(tbl[t].bytes[8*i +: 8]);
         if (tbl[t].fl) begin
            step(tbl[t].n + 2);
            flush = 1'b1;
            step(1);
            flush = 1'b0;
         end
         wait_valid(tbl[t].fl ? 2 : 6, $sformatf("vec%0d", t));
         take(tbl[t].data, tbl[t].keep, $sformatf("vec%0d", t));
      end

      // Backpressure: first word held, second fills, popping stalls, then both drain in order.
      out_ready = 1'b0;
      base = rd_ptr;
      gb = got.size();
      for (int i = 0; i < 12; i++) push(8'h10 + 8'(i));
      unstable = 0;
      for (int i = 0; i < 20; i++) begin
         step(1);
         if (out_valid && out_data !== 32'h13121110) unstable++;
      end
      chk("bp_valid", 36'(out_valid), 36'd1);
      chk("bp_hold", 36'(unstable), 36'd0);
      chk("bp_keep", 36'(out_keep), 36'hF);
      chk("bp_popped", 36'(rd_ptr - base), 36'd8);
      chk("bp_stall_ren", 36'(fifo_r_en), 36'd0);
      out_ready = 1'b1;
      step(20);
      for (int i = 0; i < 3; i++) chk($sformatf("bp_word%0d", i), got_at(gb + i), bp_exp[i]);
      exp_words += 3;
      chk("bp_words", 36'(out_words), 36'(exp_words));

      // Flush with nothing accumulated: no word, popping blocked then resumes.
      flush = 1'b1;
      push(8'h77);
      #1 chk("fl0_block_ren", 36'(fifo_r_en), 36'd0);
      step(1);
      chk("fl0_drain_ren", 36'(fifo_r_en), 36'd0);
      flush = 1'b0;
      seen = out_valid;
      n = 0;
      do begin
         step(1);
         n++;
         seen |= out_valid;
      end while (!fifo_r_en && n < 4);
      chk("fl0_resume_ren", 36'(fifo_r_en), 36'd1);
      chk("fl0_resume_fast", 36'(n <= 2), 36'd1);
      chk("fl0_no_word", 36'(seen), 36'd0);
      step(2);
      flush = 1'b1;
      step(1);
      flush = 1'b0;
      wait_valid(2, "fl1");
      take(32'h00000077, 4'h1, "fl1");

      // Reset with two bytes landed and a third in flight.
      base = rd_ptr;
      push(8'hA1); push(8'hA2); push(8'hA3);
      n = 0;
      do begin
         step(1);
         n++;
      end while (rd_ptr != base + 3 && n < 8);
      chk("rmid_popped", 36'(rd_ptr - base), 36'd3);
      rrst_n = 1'b0;
      #1;
      chk("rmid_valid", 36'(out_valid), 36'd0);
      chk("rmid_data",  36'(out_data),  36'd0);
      chk("rmid_keep",  36'(out_keep),  36'd0);
      chk("rmid_words", 36'(out_words), 36'd0);
      chk("rmid_ren",   36'(fifo_r_en), 36'd0);
      step(2);
      rrst_n = 1'b1;
      exp_words = 0;
      push(8'hB1); push(8'hB2); push(8'hB3); push(8'hB4);
      wait_valid(7, "rafter");
      take(32'hB4B3B2B1, 4'hF, "rafter");

      // Counter wrap after 65537 words, plus sustained word spacing.
      force dut.out_words = 16'hFFFF;
      step(1);
      release dut.out_words;
      gb = got.size();
      for (int i = 0; i < 8; i++) push(8'hC0 + 8'(i));
      step(16);
      chk("wrap_w0", got_at(gb), 36'hFC3C2C1C0);
      chk("wrap_w1", got_at(gb + 1), 36'hFC7C6C5C4);
      chk("wrap_words", 36'(out_words), 36'd1);
      chk("thru_gap", 36'(got_cyc.size() > gb + 1 ? got_cyc[gb + 1] - got_cyc[gb] : -1), 36'd5);

      chk("no_pop_when_empty", 36'(viol), 36'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
